// File: rtl/vlsu_txn_sched_if.sv
// vlsu_txn_sched_if
//   Bundles the handshake/bus signals of the VLSU transaction scheduler:
//   load/store burst request channels, AXI AR/AW address channels and the
//   R-last / B retirement strobes. Signal suffixes are from the scheduler's
//   point of view (_i = into the scheduler, _o = out of it).
//   Modports:
//     master - the environment side (requesters, AXI fabric)
//     slave  - the scheduler
interface vlsu_txn_sched_if #(
   parameter int unsigned AxiAddrWidth = 64
);
   logic                    ld_req_valid_i;
   logic                    ld_req_ready_o;
   logic [AxiAddrWidth-1:0] ld_req_addr_i;
   logic [7:0]              ld_req_len_i;

   logic                    st_req_valid_i;
   logic                    st_req_ready_o;
   logic [AxiAddrWidth-1:0] st_req_addr_i;
   logic [7:0]              st_req_len_i;

   logic                    ar_valid_o;
   logic                    ar_ready_i;
   logic [AxiAddrWidth-1:0] ar_addr_o;
   logic [7:0]              ar_len_o;

   logic                    aw_valid_o;
   logic                    aw_ready_i;
   logic [AxiAddrWidth-1:0] aw_addr_o;
   logic [7:0]              aw_len_o;

   logic                    r_last_hs_i;
   logic                    b_hs_i;

   modport master (
      output ld_req_valid_i, ld_req_addr_i, ld_req_len_i,
      input  ld_req_ready_o,
      output st_req_valid_i, st_req_addr_i, st_req_len_i,
      input  st_req_ready_o,
      input  ar_valid_o, ar_addr_o, ar_len_o,
      output ar_ready_i,
      input  aw_valid_o, aw_addr_o, aw_len_o,
      output aw_ready_i,
      output r_last_hs_i, b_hs_i
   );

   modport slave (
      input  ld_req_valid_i, ld_req_addr_i, ld_req_len_i,
      output ld_req_ready_o,
      input  st_req_valid_i, st_req_addr_i, st_req_len_i,
      output st_req_ready_o,
      output ar_valid_o, ar_addr_o, ar_len_o,
      input  ar_ready_i,
      output aw_valid_o, aw_addr_o, aw_len_o,
      input  aw_ready_i,
      input  r_last_hs_i, b_hs_i
   );
endinterface

// File: rtl/vlsu_txn_sched.sv
// vlsu_txn_sched
//   Schedules load/store burst requests from the VLSU onto the AXI AR/AW
//   address channels. At most one request is granted per cycle (single
//   shared address-generation slot) with round-robin priority. Each grant
//   is registered into a one-entry AR or AW output slot. Outstanding bursts
//   per direction are counted (grant +1, R-last / B -1) and capped at
//   MaxOutstanding; with fence_i set, loads and stores are never in flight
//   together.
//   Ports:
//     clk_i, rst_ni      clock, asynchronous active-low reset
//     fence_i            load/store mutual-exclusion mode
//     bus                request, AR/AW and retirement signals (slave modport)
//     ld_outstanding_o   in-flight load bursts
//     st_outstanding_o   in-flight store bursts
//     idle_o             counters zero and both output slots empty
module vlsu_txn_sched #(
   parameter int unsigned AxiAddrWidth   = 64,
   parameter int unsigned MaxOutstanding = 8,
   localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            fence_i,
   vlsu_txn_sched_if.slave bus,
   output logic [CntW-1:0] ld_outstanding_o,
   output logic [CntW-1:0] st_outstanding_o,
   output logic            idle_o
);

   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

   typedef enum logic {
      PRIO_LD = 1'b0,
      PRIO_ST = 1'b1
   } prio_e;

   prio_e                   prio_q, prio_d;

   logic                    ar_valid_q;
   logic [AxiAddrWidth-1:0] ar_addr_q;
   logic [7:0]              ar_len_q;
   logic                    aw_valid_q;
   logic [AxiAddrWidth-1:0] aw_addr_q;
   logic [7:0]              aw_len_q;

   logic [CntW-1:0]         ld_cnt_q, ld_cnt_d;
   logic [CntW-1:0]         st_cnt_q, st_cnt_d;

   logic                    ar_free, aw_free;
   logic                    ld_elig, st_elig;
   logic                    ld_gnt, st_gnt;

   // A slot is free when empty or when its current entry leaves this cycle,
   // so a saturating stream sustains one grant per cycle.
   assign ar_free = !ar_valid_q || bus.ar_ready_i;
   assign aw_free = !aw_valid_q || bus.aw_ready_i;

   assign ld_elig = bus.ld_req_valid_i && ar_free && (ld_cnt_q < MaxCnt)
                    && !(fence_i && (st_cnt_q != '0));
   assign st_elig = bus.st_req_valid_i && aw_free && (st_cnt_q < MaxCnt)
                    && !(fence_i && (ld_cnt_q != '0));

   // Arbitration: a lone eligible side always wins; on contention the
   // priority side wins and priority flips to the other side.
   always_comb begin
      prio_d = prio_q;
      ld_gnt = 1'b0;
      st_gnt = 1'b0;
      if (ld_elig && (!st_elig || (prio_q == PRIO_LD))) begin
         ld_gnt = 1'b1;
         prio_d = PRIO_ST;
      end else if (st_elig) begin
         st_gnt = 1'b1;
         prio_d = PRIO_LD;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q <= PRIO_LD;
      end else begin
         prio_q <= prio_d;
      end
   end

   // Saturating at zero: a retirement with nothing outstanding is a protocol
   // error upstream and is flagged by the assertion below.
   function automatic logic [CntW-1:0] cnt_next(input logic [CntW-1:0] cnt,
                                                input logic            inc,
                                                input logic            dec);
      logic [CntW-1:0] res;
      res = cnt;
      case ({inc, dec})
         2'b10:   res = cnt + CntW'(1);
         2'b01:   res = (cnt == '0) ? cnt : cnt - CntW'(1);
         default: res = cnt;
      endcase
      return res;
   endfunction

   always_comb begin
      ld_cnt_d = cnt_next(ld_cnt_q, ld_gnt, bus.r_last_hs_i);
      st_cnt_d = cnt_next(st_cnt_q, st_gnt, bus.b_hs_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ld_cnt_q <= '0;
         st_cnt_q <= '0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         st_cnt_q <= st_cnt_d;
      end
   end

   // Output slots: payload is only written on a grant, so it stays stable
   // while valid is held against backpressure.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ar_valid_q <= 1'b0;
         ar_addr_q  <= '0;
         ar_len_q   <= '0;
         aw_valid_q <= 1'b0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
      end else begin
         if (ld_gnt) begin
            ar_valid_q <= 1'b1;
            ar_addr_q  <= bus.ld_req_addr_i;
            ar_len_q   <= bus.ld_req_len_i;
         end else if (bus.ar_ready_i) begin
            ar_valid_q <= 1'b0;
         end
         if (st_gnt) begin
            aw_valid_q <= 1'b1;
            aw_addr_q  <= bus.st_req_addr_i;
            aw_len_q   <= bus.st_req_len_i;
         end else if (bus.aw_ready_i) begin
            aw_valid_q <= 1'b0;
         end
      end
   end

   assign bus.ld_req_ready_o = ld_gnt;
   assign bus.st_req_ready_o = st_gnt;
   assign bus.ar_valid_o     = ar_valid_q;
   assign bus.ar_addr_o      = ar_addr_q;
   assign bus.ar_len_o       = ar_len_q;
   assign bus.aw_valid_o     = aw_valid_q;
   assign bus.aw_addr_o      = aw_addr_q;
   assign bus.aw_len_o       = aw_len_q;

   assign ld_outstanding_o = ld_cnt_q;
   assign st_outstanding_o = st_cnt_q;
   assign idle_o = (ld_cnt_q == '0) && (st_cnt_q == '0) && !ar_valid_q && !aw_valid_q;

   a_ld_retire_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.r_last_hs_i && (ld_cnt_q == '0)));
   a_st_retire_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.b_hs_i && (st_cnt_q == '0)));

endmodule

// File: tb/tb_vlsu_txn_sched.sv
// tb_vlsu_txn_sched
//   Directed test of vlsu_txn_sched (AxiAddrWidth=64, MaxOutstanding=8).
//   Inputs change 1 time unit after the rising edge; all outputs are
//   sampled on the falling edge.
module tb_vlsu_txn_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       fence;
   logic [3:0] ld_out, st_out;
   logic       idle;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vlsu_txn_sched_if #(.AxiAddrWidth(64)) bus ();

   vlsu_txn_sched #(
      .AxiAddrWidth  (64),
      .MaxOutstanding(8)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .fence_i         (fence),
      .bus             (bus.slave),
      .ld_outstanding_o(ld_out),
      .st_outstanding_o(st_out),
      .idle_o          (idle)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.ld_req_valid_i = 1'b0;
      bus.ld_req_addr_i  = '0;
      bus.ld_req_len_i   = '0;
      bus.st_req_valid_i = 1'b0;
      bus.st_req_addr_i  = '0;
      bus.st_req_len_i   = '0;
      bus.ar_ready_i     = 1'b1;
      bus.aw_ready_i     = 1'b1;
      bus.r_last_hs_i    = 1'b0;
      bus.b_hs_i         = 1'b0;
      fence              = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      smp();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      nxt();
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();

      // Reset state
      smp();
      chk("rst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
      chk("rst_aw_valid", 64'(bus.aw_valid_o), 64'd0);
      chk("rst_ar_addr",  bus.ar_addr_o, 64'd0);
      chk("rst_aw_len",   64'(bus.aw_len_o), 64'd0);
      chk("rst_ld_out",   64'(ld_out), 64'd0);
      chk("rst_st_out",   64'(st_out), 64'd0);
      chk("rst_idle",     64'(idle), 64'd1);
      chk("rst_ld_ready", 64'(bus.ld_req_ready_o), 64'd0);
      #2;
      rst_n = 1'b1;
      nxt();

      // Single load 0x1000 len 3
      bus.ld_req_valid_i = 1'b1;
      bus.ld_req_addr_i  = 64'h1000;
      bus.ld_req_len_i   = 8'd3;
      smp();
      chk("single_ld_ready", 64'(bus.ld_req_ready_o), 64'd1);
      chk("single_ar_valid_c0", 64'(bus.ar_valid_o), 64'd0);
      nxt();
      bus.ld_req_valid_i = 1'b0;
      smp();
      chk("single_ar_valid_c1", 64'(bus.ar_valid_o), 64'd1);
      chk("single_ar_addr", bus.ar_addr_o, 64'h1000);
      chk("single_ar_len",  64'(bus.ar_len_o), 64'd3);
      chk("single_ld_out",  64'(ld_out), 64'd1);
      chk("single_idle_busy", 64'(idle), 64'd0);
      nxt();
      bus.r_last_hs_i = 1'b1;
      smp();
      chk("single_ar_drained", 64'(bus.ar_valid_o), 64'd0);
      chk("single_ld_out_hold", 64'(ld_out), 64'd1);
      nxt();
      bus.r_last_hs_i = 1'b0;
      smp();
      chk("single_ld_out_ret", 64'(ld_out), 64'd0);
      chk("single_idle", 64'(idle), 64'd1);

      // Round-robin alternation starting with load
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.ld_req_valid_i = 1'b1;
         bus.ld_req_addr_i  = 64'h1000 + 64'(i);
         bus.st_req_valid_i = 1'b1;
         bus.st_req_addr_i  = 64'h2000 + 64'(i);
         bus.st_req_len_i   = 8'(i);
         smp();
         chk("rr_ld_ready", 64'(bus.ld_req_ready_o), (i % 2 == 0) ? 64'd1 : 64'd0);
         chk("rr_st_ready", 64'(bus.st_req_ready_o), (i % 2 == 1) ? 64'd1 : 64'd0);
         if (i == 2) begin
            chk("rr_aw_addr", bus.aw_addr_o, 64'h2001);
            chk("rr_aw_len",  64'(bus.aw_len_o), 64'd1);
         end
         nxt();
      end
      bus.ld_req_valid_i = 1'b0;
      bus.st_req_valid_i = 1'b0;
      smp();
      chk("rr_ld_out", 64'(ld_out), 64'd2);
      chk("rr_st_out", 64'(st_out), 64'd2);
      nxt();
      bus.r_last_hs_i = 1'b1;
      bus.b_hs_i      = 1'b1;
      nxt();
      smp();
      chk("rr_ret1_ld", 64'(ld_out), 64'd1);
      chk("rr_ret1_st", 64'(st_out), 64'd1);
      nxt();
      bus.r_last_hs_i = 1'b0;
      bus.b_hs_i      = 1'b0;
      smp();
      chk("rr_ret2_ld", 64'(ld_out), 64'd0);
      chk("rr_ret2_idle", 64'(idle), 64'd1);

      // Outstanding limit: 9 loads, 8 accepted
      do_reset();
      bus.ld_req_valid_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         smp();
         chk("max_ld_ready", 64'(bus.ld_req_ready_o), (i < 8) ? 64'd1 : 64'd0);
         nxt();
      end
      bus.r_last_hs_i = 1'b1;
      smp();
      chk("max_ld_out_full", 64'(ld_out), 64'd8);
      chk("max_stall_on_ret", 64'(bus.ld_req_ready_o), 64'd0);
      nxt();
      bus.r_last_hs_i = 1'b0;
      smp();
      chk("max_ld_out_7", 64'(ld_out), 64'd7);
      chk("max_9th_ready", 64'(bus.ld_req_ready_o), 64'd1);
      nxt();
      bus.ld_req_valid_i = 1'b0;
      smp();
      chk("max_ld_out_8", 64'(ld_out), 64'd8);

      // Fence: load waits for store to retire
      do_reset();
      fence = 1'b1;
      bus.st_req_valid_i = 1'b1;
      bus.st_req_addr_i  = 64'h7000;
      smp();
      chk("fence_st_ready", 64'(bus.st_req_ready_o), 64'd1);
      nxt();
      bus.st_req_valid_i = 1'b0;
      bus.ld_req_valid_i = 1'b1;
      smp();
      chk("fence_st_out", 64'(st_out), 64'd1);
      chk("fence_ld_blocked0", 64'(bus.ld_req_ready_o), 64'd0);
      nxt();
      bus.b_hs_i = 1'b1;
      smp();
      chk("fence_ld_blocked1", 64'(bus.ld_req_ready_o), 64'd0);
      nxt();
      bus.b_hs_i = 1'b0;
      smp();
      chk("fence_st_out_ret", 64'(st_out), 64'd0);
      chk("fence_ld_granted", 64'(bus.ld_req_ready_o), 64'd1);

      // Fence with both sides valid and idle: priority (load) wins
      do_reset();
      fence = 1'b1;
      bus.ld_req_valid_i = 1'b1;
      bus.st_req_valid_i = 1'b1;
      smp();
      chk("fence_both_ld", 64'(bus.ld_req_ready_o), 64'd1);
      chk("fence_both_st", 64'(bus.st_req_ready_o), 64'd0);
      nxt();
      smp();
      chk("fence_both_st_wait", 64'(bus.st_req_ready_o), 64'd0);
      chk("fence_both_ld_again", 64'(bus.ld_req_ready_o), 64'd1);

      // AR backpressure
      do_reset();
      bus.ar_ready_i     = 1'b0;
      bus.ld_req_valid_i = 1'b1;
      bus.ld_req_addr_i  = 64'h3000;
      bus.ld_req_len_i   = 8'd7;
      smp();
      chk("bp_first_ready", 64'(bus.ld_req_ready_o), 64'd1);
      nxt();
      bus.ld_req_addr_i = 64'h4000;
      bus.ld_req_len_i  = 8'd1;
      for (int i = 0; i < 5; i++) begin
         smp();
         chk("bp_blocked", 64'(bus.ld_req_ready_o), 64'd0);
         chk("bp_valid",   64'(bus.ar_valid_o), 64'd1);
         chk("bp_addr",    bus.ar_addr_o, 64'h3000);
         chk("bp_len",     64'(bus.ar_len_o), 64'd7);
         nxt();
      end
      bus.ar_ready_i = 1'b1;
      smp();
      chk("bp_release_ready", 64'(bus.ld_req_ready_o), 64'd1);
      nxt();
      bus.ld_req_valid_i = 1'b0;
      smp();
      chk("bp_next_valid", 64'(bus.ar_valid_o), 64'd1);
      chk("bp_next_addr",  bus.ar_addr_o, 64'h4000);
      chk("bp_next_len",   64'(bus.ar_len_o), 64'd1);
      chk("bp_ld_out",     64'(ld_out), 64'd2);

      // Simultaneous grant and retire at ld=3
      nxt();
      bus.ld_req_valid_i = 1'b1;
      bus.ld_req_addr_i  = 64'h5000;
      smp();
      chk("sim_grant_a", 64'(bus.ld_req_ready_o), 64'd1);
      nxt();
      bus.r_last_hs_i = 1'b1;
      smp();
      chk("sim_ld_out_3", 64'(ld_out), 64'd3);
      chk("sim_grant_b", 64'(bus.ld_req_ready_o), 64'd1);
      nxt();
      bus.ld_req_valid_i = 1'b0;
      bus.r_last_hs_i    = 1'b0;
      smp();
      chk("sim_ld_out_hold", 64'(ld_out), 64'd3);
      chk("sim_ar_valid", 64'(bus.ar_valid_o), 64'd1);

      // Asynchronous reset mid-burst (no clock edge in between)
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ar_valid", 64'(bus.ar_valid_o), 64'd0);
      chk("arst_ar_addr",  bus.ar_addr_o, 64'd0);
      chk("arst_ld_out",   64'(ld_out), 64'd0);
      chk("arst_idle",     64'(idle), 64'd1);
      #1;
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
